psram_brst_sched: RTL



---
 rtl/psram_brst_sched_pkg.sv | 27 ++
 rtl/psram_brst_sched_addr_gen.sv | 62 ++++++
 rtl/psram_brst_sched.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/psram_brst_sched_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | psram_brst_sched_pkg : shared burst constants and scheduler state encoding |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package psram_brst_sched_pkg;

  // Burst length shared with the PSRAM burst controller.
  localparam int Burst_length = 32;

  localparam int ADDR_W   = 23;
  localparam int CFG_HOLD = 16;

  localparam logic DIR_WR = 1'b1;
  localparam logic DIR_RD = 1'b0;

  typedef enum logic [2:0] {
    s_sch_wait_cfg  = 3'd0,
    s_sch_idle      = 3'd1,
    s_sch_issue     = 3'd2,
    s_sch_wait_ack  = 3'd3,
    s_sch_wait_done = 3'd4,
    s_sch_update    = 3'd5
  } sch_state_e;

endpackage
`default_nettype wire

// File: rtl/psram_brst_sched_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | psram_addr_gen : per-direction linear frame pointer with deferred restart |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module psram_addr_gen
  import psram_brst_sched_pkg::*;
#(
  parameter int                BURST_LEN   = Burst_length,
  parameter int                FRAME_WORDS = 307200,
  parameter logic [ADDR_W-1:0] BASE        = 23'd0
) (
  input  logic              clk_i,
  input  logic              rst,
  input  logic              frame_start_i,
  input  logic              apply_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] ptr_o
);

  localparam logic [ADDR_W-1:0] c_STEP  = ADDR_W'(BURST_LEN);
  localparam logic [ADDR_W-1:0] c_FRAME = ADDR_W'(FRAME_WORDS);

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] w_next;
  logic [ADDR_W-1:0] w_off;
  logic              w_restart;
  logic              w_clear;

  assign w_next    = ptr_q + c_STEP;
  assign w_off     = w_next - BASE;
  // A pulse in the same cycle counts as pending so the restart is never lost.
  assign w_restart = pend_q | frame_start_i;
  assign w_clear   = apply_i & w_restart;

  // The arbiter sees the restart address as soon as it is allowed to apply.
  assign ptr_o = w_clear ? BASE : ptr_q;

  always_comb begin
    ptr_d  = ptr_q;
    pend_d = w_restart;
    if (w_clear) begin
      ptr_d  = BASE;
      pend_d = 1'b0;
    end else if (advance_i) begin
      ptr_d = (w_off == c_FRAME) ? BASE : w_next;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      ptr_q  <= BASE;
      pend_q <= 1'b0;
    end else begin
      ptr_q  <= ptr_d;
      pend_q <= pend_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/psram_brst_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | psram_brst_sched : shares the PSRAM burst port between write and readout |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module psram_brst_sched
  import psram_brst_sched_pkg::*;
#(
  parameter int                BURST_LEN   = Burst_length,
  parameter int                FRAME_WORDS = 307200,
  parameter logic [ADDR_W-1:0] WR_BASE     = 23'd0,
  parameter logic [ADDR_W-1:0] RD_BASE     = 23'd0,
  parameter int                ACK_TO      = 15
) (
  input  logic              clk160_i,
  input  logic              rst,
  input  logic              cfgDone,
  input  logic              wr_req,
  input  logic              wr_urgent,
  input  logic              rd_req,
  input  logic              wr_frame_start,
  input  logic              rd_frame_start,
  output logic              brst_Go,
  output logic [ADDR_W-1:0] brst_Addr_in,
  output logic              brst_Wr,
  input  logic              brst_Done,
  output logic              wr_grant,
  output logic              rd_grant,
  output logic              busy,
  output logic              err
);

  localparam int c_ACK_W = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

  sch_state_e          state_q, state_d;
  logic [3:0]          cfg_cnt_q, cfg_cnt_d;
  logic [c_ACK_W-1:0]  ack_cnt_q, ack_cnt_d;
  logic                dir_q, dir_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic                go_q, busy_q, wr_grant_q, rd_grant_q;

  logic                w_wr_apply, w_rd_apply, w_wr_adv, w_rd_adv;
  logic [ADDR_W-1:0]   w_wr_ptr, w_rd_ptr;
  logic                w_win, w_pick_wr;

  psram_addr_gen #(
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS),
    .BASE        (WR_BASE)
  ) u_wr_addr (
    .clk_i         (clk160_i),
    .rst           (rst),
    .frame_start_i (wr_frame_start),
    .apply_i       (w_wr_apply),
    .advance_i     (w_wr_adv),
    .ptr_o         (w_wr_ptr)
  );

  psram_addr_gen #(
    .BURST_LEN   (BURST_LEN),
    .FRAME_WORDS (FRAME_WORDS),
    .BASE        (RD_BASE)
  ) u_rd_addr (
    .clk_i         (clk160_i),
    .rst           (rst),
    .frame_start_i (rd_frame_start),
    .apply_i       (w_rd_apply),
    .advance_i     (w_rd_adv),
    .ptr_o         (w_rd_ptr)
  );

  // Urgent write first, then alternate on a tie, else the lone requester.
  always_comb begin
    w_win     = 1'b0;
    w_pick_wr = 1'b0;
    if (wr_urgent && wr_req) begin
      w_win     = 1'b1;
      w_pick_wr = 1'b1;
    end else if (wr_req && rd_req) begin
      w_win     = 1'b1;
      w_pick_wr = (last_q == DIR_RD);
    end else if (wr_req || rd_req) begin
      w_win     = 1'b1;
      w_pick_wr = wr_req;
    end
  end

  always_comb begin
    state_d    = state_q;
    cfg_cnt_d  = cfg_cnt_q;
    ack_cnt_d  = ack_cnt_q;
    dir_d      = dir_q;
    addr_d     = addr_q;
    last_d     = last_q;
    err_d      = err_q;
    w_wr_apply = 1'b0;
    w_rd_apply = 1'b0;
    w_wr_adv   = 1'b0;
    w_rd_adv   = 1'b0;

    if (!cfgDone) begin
      state_d   = s_sch_wait_cfg;
      cfg_cnt_d = 4'd0;
    end else begin
      case (state_q)
        s_sch_wait_cfg: begin
          if (brst_Done) begin
            if (cfg_cnt_q == 4'(CFG_HOLD - 1)) begin
              state_d   = s_sch_idle;
              cfg_cnt_d = 4'd0;
            end else begin
              cfg_cnt_d = cfg_cnt_q + 4'd1;
            end
          end else begin
            cfg_cnt_d = 4'd0;
          end
        end
        s_sch_idle: begin
          w_wr_apply = 1'b1;
          w_rd_apply = 1'b1;
          if (brst_Done && w_win) begin
            dir_d   = w_pick_wr ? DIR_WR : DIR_RD;
            addr_d  = w_pick_wr ? w_wr_ptr : w_rd_ptr;
            state_d = s_sch_issue;
          end
        end
        s_sch_issue: begin
          ack_cnt_d = '0;
          state_d   = s_sch_wait_ack;
        end
        s_sch_wait_ack: begin
          if (!brst_Done) begin
            state_d = s_sch_wait_done;
          end else if (ack_cnt_q == c_ACK_W'(ACK_TO - 1)) begin
            err_d   = 1'b1;
            state_d = s_sch_idle;
          end else begin
            ack_cnt_d = ack_cnt_q + 1'b1;
          end
        end
        s_sch_wait_done: begin
          if (brst_Done) state_d = s_sch_update;
        end
        s_sch_update: begin
          w_wr_apply = 1'b1;
          w_rd_apply = 1'b1;
          w_wr_adv   = (dir_q == DIR_WR);
          w_rd_adv   = (dir_q == DIR_RD);
          last_d     = dir_q;
          state_d    = s_sch_idle;
        end
        default: state_d = s_sch_wait_cfg;
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state.
  always_ff @(posedge clk160_i) begin
    if (rst) begin
      state_q    <= s_sch_wait_cfg;
      cfg_cnt_q  <= 4'd0;
      ack_cnt_q  <= '0;
      dir_q      <= DIR_RD;
      addr_q     <= '0;
      last_q     <= DIR_RD;
      err_q      <= 1'b0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      wr_grant_q <= 1'b0;
      rd_grant_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_cnt_q  <= cfg_cnt_d;
      ack_cnt_q  <= ack_cnt_d;
      dir_q      <= dir_d;
      addr_q     <= addr_d;
      last_q     <= last_d;
      err_q      <= err_d;
      go_q       <= (state_d == s_sch_issue);
      busy_q     <= (state_d inside {s_sch_issue, s_sch_wait_ack,
                                     s_sch_wait_done, s_sch_update});
      wr_grant_q <= (state_d == s_sch_update) && (dir_d == DIR_WR);
      rd_grant_q <= (state_d == s_sch_update) && (dir_d == DIR_RD);
    end
  end

  assign brst_Go      = go_q;
  assign brst_Addr_in = addr_q;
  assign brst_Wr      = dir_q;
  assign wr_grant     = wr_grant_q;
  assign rd_grant     = rd_grant_q;
  assign busy         = busy_q;
  assign err          = err_q;

endmodule
`default_nettype wire
